// File: rtl/montgomery_array_ctrl.sv
// montgomery_array_ctrl
// Sequences one bit-serial Montgomery multiplication R = A*B*2^-WIDTH mod N
// on an external systolic processing-element array. The controller owns the
// A shift register, the accumulator, the iteration counter and the
// precomputed B / B+N operands. The array returns (acc + ai*B + q*N)/2
// combinationally, and that value is latched once per iteration.
//
// Optional feature macro: FINAL_SUB_EN
//   defined   -> a SUB state applies the final conditional subtraction, so the
//                result is fully reduced into [0,N).
//   undefined -> ITER goes straight to DONE and the result is acc[WIDTH-1:0].
//
// state_dbg exposes the FSM state encoding (0 IDLE, 1 ITER, 2 SUB, 3 DONE).
`timescale 1ns/1ps

module montgomery_array_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] n_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             arr_ai,
    output logic [WIDTH:0]   arr_b,
    output logic [WIDTH:0]   arr_bn,
    output logic [WIDTH:0]   arr_acc,
    input  logic [WIDTH:0]   arr_acc_next,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH:0]   acc;
    logic [CW-1:0]    cnt;
    logic             last_iter;

`ifdef FINAL_SUB_EN
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH:0]   n_ext;
    logic [WIDTH:0]   sub_val;

    // Final reduction: one subtraction of N, compared at WIDTH+1 bits.
    always_comb begin
        n_ext   = {1'b0, n_reg};
        sub_val = acc;
        if (acc >= n_ext) begin
            sub_val = acc - n_ext;
        end
    end
`endif

    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign arr_ai    = a_sr[0];
    assign arr_acc   = acc;
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start is honoured only in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ITER;
                end
            end
            S_ITER: begin
                if (last_iter) begin
`ifdef FINAL_SUB_EN
                    state_nxt = S_SUB;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_SUB:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, per-iteration accumulate/shift, result load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            arr_b  <= '0;
            arr_bn <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
`ifdef FINAL_SUB_EN
            n_reg  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr   <= a_in;
                        arr_b  <= {1'b0, b_in};
                        arr_bn <= {1'b0, b_in} + {1'b0, n_in};
                        acc    <= '0;
                        cnt    <= '0;
`ifdef FINAL_SUB_EN
                        n_reg  <= n_in;
`endif
                    end
                end
                S_ITER: begin
                    acc  <= arr_acc_next;
                    a_sr <= a_sr >> 1;
                    cnt  <= cnt + CW'(1);
`ifndef FINAL_SUB_EN
                    // Last latch edge feeds DONE directly, so load the result now.
                    if (last_iter) begin
                        result <= arr_acc_next[WIDTH-1:0];
                    end
`endif
                end
`ifdef FINAL_SUB_EN
                S_SUB: begin
                    acc    <= sub_val;
                    result <= sub_val[WIDTH-1:0];
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_array_ctrl.sv
// tb_montgomery_array_ctrl
// Bench for montgomery_array_ctrl at WIDTH=4 with a behavioural model of the
// processing-element array. Works with or without FINAL_SUB_EN; the reference
// model and the expected latency follow the same macro.
`timescale 1ns/1ps

module tb_montgomery_array_ctrl;

    localparam int W = 4;
`ifdef FINAL_SUB_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] n_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         arr_ai;
    logic [W:0]   arr_b;
    logic [W:0]   arr_bn;
    logic [W:0]   arr_acc;
    logic [W:0]   arr_acc_next;
    logic [1:0]   state_dbg;

    int           checks;
    int           failures;
    int           done_cnt;
    int           pulses_exp;
    logic [W-1:0] n_model;
    logic [W-1:0] exp_q[$];

    montgomery_array_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a_in         (a_in),
        .b_in         (b_in),
        .n_in         (n_in),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .arr_ai       (arr_ai),
        .arr_b        (arr_b),
        .arr_bn       (arr_bn),
        .arr_acc      (arr_acc),
        .arr_acc_next (arr_acc_next),
        .state_dbg    (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PE array: q from acc LSB and ai*B LSB, then (acc + ai*B + q*N)/2.
    logic       q_m;
    logic [W:0] add_m;
    logic [W+1:0] sum_m;
    assign q_m   = arr_acc[0] ^ (arr_ai & arr_b[0]);
    assign add_m = arr_ai ? (q_m ? arr_bn : arr_b) : (q_m ? {1'b0, n_model} : '0);
    assign sum_m = {1'b0, arr_acc} + {1'b0, add_m};
    assign arr_acc_next = sum_m[W+1:1];

    // Count done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference bit-serial Montgomery product.
    function automatic logic [W-1:0] mont_ref(input int a, input int b, input int n);
        int r;
        r = 0;
        for (int i = 0; i < W; i++) begin
            if (((a >> i) & 1) == 1) r = r + b;
            if ((r & 1) == 1) r = r + n;
            r = r >> 1;
        end
`ifdef FINAL_SUB_EN
        if (r >= n) r = r - n;
`endif
        return W'(r);
    endfunction

    // One product: drive start, optionally pulse start at cycle ign_at while
    // busy and/or in the DONE cycle, then check latency, result and pulse count.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n,
                          input int ign_at, input bit ign_done, output int ai_ones);
        int           lat;
        int           busy_bad;
        logic [W-1:0] exp_v;
        lat      = 0;
        busy_bad = 0;
        ai_ones  = 0;
        @(negedge clk);
        a_in    = a;
        b_in    = b;
        n_in    = n;
        start   = 1'b1;
        n_model = n;
        exp_q.push_back(mont_ref(int'(a), int'(b), int'(n)));
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = W'($urandom_range(0, 15));
        b_in  = W'($urandom_range(0, 15));
        n_in  = W'($urandom_range(0, 15));
        if (arr_ai) ai_ones++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_bad++;
            if (arr_ai) ai_ones++;
            if (k == ign_at) begin
                start = 1'b1;
                a_in  = W'($urandom_range(0, 15));
                b_in  = W'($urandom_range(0, 15));
                n_in  = W'($urandom_range(0, 15)) | 4'd1;
            end
        end
        check_eq("done_seen", 32'(lat != 0), 32'd1);
        check_eq("latency", 32'(lat), 32'(LAT));
        check_eq("busy_during_op", 32'(busy_bad), 32'd0);
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp_v = exp_q.pop_front();
            check_eq("result", 32'(result), 32'(exp_v));
        end
        pulses_exp++;
        if (ign_done) begin
            start = 1'b1;
            a_in  = W'($urandom_range(0, 15));
            n_in  = 4'd13;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("idle_after_done", 32'(busy), 32'd0);
        check_eq("done_pulses", 32'(done_cnt), 32'(pulses_exp));
    endtask

    // Stimulus and checks.
    initial begin
        int ai_ones;
        int ra, rb, rn;
        checks     = 0;
        failures   = 0;
        done_cnt   = 0;
        pulses_exp = 0;
        n_model    = '0;
        rst        = 1'b1;
        start      = 1'b0;
        a_in       = '0;
        b_in       = '0;
        n_in       = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_arr_ai", 32'(arr_ai), 32'd0);
        check_eq("rst_arr_b", 32'(arr_b), 32'd0);
        check_eq("rst_arr_bn", 32'(arr_bn), 32'd0);
        check_eq("rst_arr_acc", 32'(arr_acc), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'd7, 4'd5, 4'd13, 0, 1'b0, ai_ones);
        run_op(4'd1, 4'd1, 4'd13, 0, 1'b0, ai_ones);
        run_op(4'd0, 4'd12, 4'd13, 0, 1'b0, ai_ones);
        check_eq("a_zero_ai", 32'(ai_ones), 32'd0);
        // Start pulses inside ITER and in the DONE cycle are dropped.
        run_op(4'd3, 4'd10, 4'd13, 2, 1'b1, ai_ones);
        // Back-to-back: next start lands in the cycle after DONE.
        run_op(4'd11, 4'd6, 4'd13, 0, 1'b0, ai_ones);
        run_op(4'd12, 4'd12, 4'd13, 0, 1'b0, ai_ones);
`ifndef FINAL_SUB_EN
        run_op(4'd7, 4'd5, 4'd5, 0, 1'b0, ai_ones);
`endif

        // Reset during ITER with cnt=2 aborts without a done pulse.
        @(negedge clk);
        a_in    = 4'd9;
        b_in    = 4'd4;
        n_in    = 4'd13;
        n_model = 4'd13;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("mid_iter_state", 32'(state_dbg), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_result", 32'(result), 32'd0);
        check_eq("abort_acc", 32'(arr_acc), 32'd0);
        check_eq("abort_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("no_done_after_abort", 32'(done_cnt), 32'(pulses_exp));

        run_op(4'd9, 4'd8, 4'd11, 0, 1'b0, ai_ones);

        // Random operands satisfying N odd, A,B < N.
        for (int i = 0; i < 8; i++) begin
            rn = $urandom_range(1, 7) * 2 + 1;
            ra = $urandom_range(0, rn - 1);
            rb = $urandom_range(0, rn - 1);
`ifndef FINAL_SUB_EN
            rn = $urandom_range(1, 3) * 2 + 1;
            ra = $urandom_range(0, rn - 1);
            rb = $urandom_range(0, rn - 1);
`endif
            run_op(W'(ra), W'(rb), W'(rn), (i % 3 == 0) ? 1 : 0, (i % 2 == 1), ai_ones);
        end

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
